// File: rtl/wdi_feed_gen.sv
// Watchdog feed (WDI) generator: square-wave feed while healthy, permanent starve on filtered fault or request.
// Optional macro WDI_PULSE_MODE_EN replaces the square wave with PULSE_W-cycle pulses every 2*HALF_PERIOD cycles.
module wdi_feed_gen #(
  parameter int HALF_PERIOD = 20000,
  parameter int START_DLY   = 2000,
  parameter int FAULT_FILT  = 200,
  parameter int PULSE_W     = 4
) (
  input  logic       i_clk,
  input  logic       reset_n,
  input  logic       i_en,
  input  logic       i_WD_DSP_ERR,
  input  logic       i_XINT_DSP_ERR,
  input  logic       i_force_starve,
  output logic       o_WDI,
  output logic       o_feed_active,
  output logic       o_starving,
  output logic [2:0] o_fault_cause
);

  localparam int HW = $clog2(HALF_PERIOD) + 1;
  localparam int SW = $clog2(START_DLY) + 1;
  localparam int FW = $clog2(FAULT_FILT) + 1;
  localparam logic [HW-1:0] HP_LAST    = HW'(HALF_PERIOD - 1);
  localparam logic [SW-1:0] START_LAST = SW'(START_DLY - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FAULT_FILT - 1);

  // Reject parameter sets that would break the counters or let pulses overlap.
  if (HALF_PERIOD < 2 || FAULT_FILT < 1 || PULSE_W >= 2 * HALF_PERIOD) begin : g_bad_params
    $error("wdi_feed_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, FEED, PENDING, STARVE} state_t;

  state_t         state;
  logic [SW-1:0]  start_cnt;
  logic [HW-1:0]  hp_cnt;
  logic [FW-1:0]  filt_cnt;
  logic           fault;
  logic           wrap;

`ifdef WDI_PULSE_MODE_EN
  localparam int PW = $clog2(PULSE_W) + 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_W - 1);
  logic           phase;
  logic [PW-1:0]  pulse_cnt;
`endif

  assign fault = i_WD_DSP_ERR | i_XINT_DSP_ERR;
  assign wrap  = (hp_cnt == HP_LAST);

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      start_cnt     <= '0;
      hp_cnt        <= '0;
      filt_cnt      <= '0;
      o_WDI         <= 1'b0;
      o_feed_active <= 1'b0;
      o_starving    <= 1'b0;
      o_fault_cause <= '0;
`ifdef WDI_PULSE_MODE_EN
      phase         <= 1'b0;
      pulse_cnt     <= '0;
`endif
    end else begin
`ifdef WDI_PULSE_MODE_EN
      // A running pulse always finishes, even after entering STARVE.
      if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - 1'b1;
      else                 o_WDI     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!i_en) begin
            start_cnt <= '0;
          end else if (start_cnt == START_LAST) begin
            state         <= FEED;
            start_cnt     <= '0;
            hp_cnt        <= '0;
            o_feed_active <= 1'b1;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        FEED, PENDING: begin
          if (i_force_starve) begin
            state         <= STARVE;
            o_feed_active <= 1'b0;
            o_starving    <= 1'b1;
            o_fault_cause <= o_fault_cause | {1'b1, i_XINT_DSP_ERR, i_WD_DSP_ERR};
          end else if (!i_en) begin
            state         <= IDLE;
            o_feed_active <= 1'b0;
            o_WDI         <= 1'b0;
            hp_cnt        <= '0;
            filt_cnt      <= '0;
`ifdef WDI_PULSE_MODE_EN
            phase         <= 1'b0;
            pulse_cnt     <= '0;
`endif
          end else if (fault && filt_cnt == FILT_LAST) begin
            // WDI is frozen at the level it already has on the entry cycle.
            state         <= STARVE;
            o_feed_active <= 1'b0;
            o_starving    <= 1'b1;
            o_fault_cause <= o_fault_cause | {1'b0, i_XINT_DSP_ERR, i_WD_DSP_ERR};
          end else begin
            hp_cnt <= wrap ? '0 : hp_cnt + 1'b1;
`ifdef WDI_PULSE_MODE_EN
            if (wrap) begin
              phase <= ~phase;
              if (!phase) begin
                o_WDI     <= 1'b1;
                pulse_cnt <= PULSE_LAST;
              end
            end
`else
            if (wrap) o_WDI <= ~o_WDI;
`endif
            if (fault) begin
              state    <= PENDING;
              filt_cnt <= filt_cnt + 1'b1;
            end else begin
              state    <= FEED;
              filt_cnt <= '0;
            end
          end
        end
        default: begin
          state <= STARVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wdi_feed_gen.sv
// Directed bench for wdi_feed_gen: expected output words queued per step, popped and asserted at the falling edge.
module tb_wdi_feed_gen;

  localparam int HALF_PERIOD = 4;
  localparam int START_DLY   = 10;
  localparam int FAULT_FILT  = 3;
  localparam int PULSE_W     = 2;
  localparam int FIRST_RISE  = START_DLY + HALF_PERIOD;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       wd_err;
  logic       xint_err;
  logic       force_starve;
  logic       wdi;
  logic       feed_active;
  logic       starving;
  logic [2:0] fault_cause;

  logic [5:0] exp_q[$];
  int         tests;
  int         fails;
  logic       frozen;

  wdi_feed_gen #(
    .HALF_PERIOD(HALF_PERIOD),
    .START_DLY  (START_DLY),
    .FAULT_FILT (FAULT_FILT),
    .PULSE_W    (PULSE_W)
  ) dut (
    .i_clk         (clk),
    .reset_n       (rst_n),
    .i_en          (en),
    .i_WD_DSP_ERR  (wd_err),
    .i_XINT_DSP_ERR(xint_err),
    .i_force_starve(force_starve),
    .o_WDI         (wdi),
    .o_feed_active (feed_active),
    .o_starving    (starving),
    .o_fault_cause (fault_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected WDI level after clock edge k since enable, for an uninterrupted feed.
  function automatic logic wdi_at(input int k);
`ifdef WDI_PULSE_MODE_EN
    return (k >= FIRST_RISE) && (((k - FIRST_RISE) % (2 * HALF_PERIOD)) < PULSE_W);
`else
    return (k >= FIRST_RISE) && ((((k - FIRST_RISE) / HALF_PERIOD) % 2) == 0);
`endif
  endfunction

  task automatic check_out(input string tag);
    logic [5:0] want;
    logic [5:0] obs;
    obs = {wdi, feed_active, starving, fault_cause};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %b but scoreboard queue empty", tag, obs);
      return;
    end
    want = exp_q.pop_front();
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed {wdi,fa,st,cause}=%b expected %b", tag, obs, want);
    end
  endtask

  task automatic cyc(input string tag, input logic wd, input logic xint, input logic frc,
                     input logic [5:0] want);
    wd_err       = wd;
    xint_err     = xint;
    force_starve = frc;
    exp_q.push_back(want);
    @(negedge clk);
    check_out(tag);
  endtask

  task automatic do_reset();
    wd_err       = 1'b0;
    xint_err     = 1'b0;
    force_starve = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(6'b000000);
    check_out("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic startup(input string tag, input int n);
    for (int k = 1; k <= n; k++)
      cyc(tag, 1'b0, 1'b0, 1'b0, {wdi_at(k), (k >= START_DLY), 1'b0, 3'b000});
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst_n        = 1'b1;
    en           = 1'b1;
    wd_err       = 1'b0;
    xint_err     = 1'b0;
    force_starve = 1'b0;
    #1;

    do_reset();
    startup("startup", 25);

    // Two-cycle fault stays below the filter; feeding continues in phase.
    for (int k = 26; k <= 37; k++)
      cyc("glitch", (k == 27 || k == 28), 1'b0, 1'b0, {wdi_at(k), 1'b1, 1'b0, 3'b000});

    // Three-cycle fault reaches the filter and starves.
    for (int k = 38; k <= 39; k++)
      cyc("filt_pending", 1'b0, 1'b1, 1'b0, {wdi_at(k), 1'b1, 1'b0, 3'b000});
    frozen = wdi_at(40);
    cyc("filt_starve", 1'b0, 1'b1, 1'b0, {frozen, 1'b0, 1'b1, 3'b010});
    for (int i = 0; i < 10; i++) begin
      en = (i < 5);
      cyc("starve_latched", (i == 2), (i == 6), (i == 3), {frozen, 1'b0, 1'b1, 3'b010});
    end
    en = 1'b1;

    // Asynchronous reset in STARVE clears outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(6'b000000);
    check_out("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    startup("restart", 14);

    // Force starve with WD fault in the same cycle, mid pulse in pulse mode.
    cyc("force_fault", 1'b1, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 3'b101});
`ifdef WDI_PULSE_MODE_EN
    frozen = 1'b0;
`else
    frozen = 1'b1;
`endif
    for (int i = 0; i < 6; i++)
      cyc("force_hold", 1'b0, 1'b0, 1'b0, {frozen, 1'b0, 1'b1, 3'b101});

    // Force starve and faults in IDLE are ignored.
    en = 1'b0;
    do_reset();
    cyc("idle_force", 1'b0, 1'b0, 1'b1, 6'b000000);
    cyc("idle_fault", 1'b1, 1'b1, 1'b0, 6'b000000);
    cyc("idle_quiet", 1'b0, 1'b0, 1'b0, 6'b000000);
    en = 1'b1;
    startup("en_start", 14);

    // Enable drop returns to IDLE with WDI low; re-enable restarts the delay.
    en = 1'b0;
    cyc("en_drop", 1'b0, 1'b0, 1'b0, 6'b000000);
    for (int i = 0; i < 3; i++)
      cyc("en_low", 1'b0, 1'b0, 1'b0, 6'b000000);
    en = 1'b1;
    startup("en_resume", 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
